ring_router_input_demux: RTL and testbench

Ingress stage of a ring router that feeds the round-robin output mux. It accepts DII flits from the upstream ring link, decodes the destination ID in each packet's header flit, and steers the whole worm either to the local endpoint or onward toward the ring output mux. It optionally registers the ingress path through a 2-entry skid buffer.

---
 rtl/ring_router_input_demux.sv | 113 +++++++++++
 tb/tb_ring_router_input_demux.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_input_demux.sv
// Ring router ingress: steers each DII worm to the local port or onward to the ring mux.
// Define RING_ROUTER_INPUT_DEMUX_SKID_EN to insert a 2-entry skid FIFO on the ingress path.
module ring_router_input_demux #(
  parameter logic [15:0] ID = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_local_valid_o,
  output logic        out_local_last_o,
  output logic [15:0] out_local_data_o,
  input  logic        out_local_ready_i,
  output logic        out_ring_valid_o,
  output logic        out_ring_last_o,
  output logic [15:0] out_ring_data_o,
  input  logic        out_ring_ready_i
);

  typedef enum logic [1:0] {StIdle, StWormLocal, StWormRing} state_e;

  state_e      state_q;
  logic        head_valid;
  logic        head_last;
  logic [15:0] head_data;
  logic        sel_local;
  logic        sel_ready;
  logic        pop;

`ifdef RING_ROUTER_INPUT_DEMUX_SKID_EN
  logic [16:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q;
  logic        push;

  assign push       = in_valid_i & in_ready_q;
  assign head_valid = (count_q != 2'd0);
  assign head_last  = mem_q[rd_ptr_q][16];
  assign head_data  = mem_q[rd_ptr_q][15:0];
  assign in_ready_o = in_ready_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      // Registered ready: reflects whether a slot is free after this edge.
      in_ready_q <= (count_d != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last_i, in_data_i};
  end
`else
  assign head_valid = in_valid_i;
  assign head_last  = in_last_i;
  assign head_data  = in_data_i;
  assign in_ready_o = sel_ready;
`endif

  always_comb begin
    unique case (state_q)
      StIdle:      sel_local = (head_data == ID);
      StWormLocal: sel_local = 1'b1;
      default:     sel_local = 1'b0;
    endcase
  end

  assign sel_ready = sel_local ? out_local_ready_i : out_ring_ready_i;
  assign pop       = head_valid & sel_ready;

  assign out_local_valid_o = head_valid & sel_local;
  assign out_local_last_o  = head_last;
  assign out_local_data_o  = head_data;
  assign out_ring_valid_o  = head_valid & ~sel_local;
  assign out_ring_last_o   = head_last;
  assign out_ring_data_o   = head_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (pop) begin
      unique case (state_q)
        StIdle: begin
          // Single-flit packets never leave idle.
          if (!head_last) state_q <= sel_local ? StWormLocal : StWormRing;
        end
        default: begin
          if (head_last) state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_router_input_demux.sv
// Scoreboard bench for ring_router_input_demux; a packet-level model predicts each flit's port.
module tb_ring_router_input_demux;

  localparam logic [15:0] ID = 16'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready;
  logic        lv, ll, lr = 1'b1;
  logic [15:0] ld;
  logic        rv, rl, rr = 1'b1;
  logic [15:0] rd;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        to_local;
    logic        last;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   model_hdr = 1'b1;
  bit   model_local = 1'b0;
  bit   prev_l_stall = 1'b0, prev_r_stall = 1'b0;
  logic [16:0] prev_l, prev_r;
  bit   rand_ready = 1'b0;

  ring_router_input_demux #(.ID(ID)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid_i        (in_valid),
    .in_last_i         (in_last),
    .in_data_i         (in_data),
    .in_ready_o        (in_ready),
    .out_local_valid_o (lv),
    .out_local_last_o  (ll),
    .out_local_data_o  (ld),
    .out_local_ready_i (lr),
    .out_ring_valid_o  (rv),
    .out_ring_last_o   (rl),
    .out_ring_data_o   (rd),
    .out_ring_ready_i  (rr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input logic to_local, input logic last, input logic [15:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_flit: actual port_local=%0d data=%0h, required no output", to_local,
               data);
    end else begin
      e = exp_q.pop_front();
      check("flit_port_local", {31'd0, to_local}, {31'd0, e.to_local});
      check("flit_data", {16'd0, data}, {16'd0, e.data});
      check("flit_last", {31'd0, last}, {31'd0, e.last});
    end
  endtask

  // Input observer runs before the output monitor so zero-latency flits are queued first.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_hdr    = 1'b1;
      prev_l_stall = 1'b0;
      prev_r_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (model_hdr) model_local = (in_data == ID);
        exp_q.push_back({model_local, in_last, in_data});
        model_hdr = in_last;
      end
      if (lv || rv) check("one_hot_valid", {30'd0, lv, rv} == 32'd3, 32'd0);
      if (prev_l_stall) check("hold_local", {14'd0, lv, ll, ld}, {15'd1, prev_l});
      if (prev_r_stall) check("hold_ring", {14'd0, rv, rl, rd}, {15'd1, prev_r});
      if (lv && lr) pop_check(1'b1, ll, ld);
      if (rv && rr) pop_check(1'b0, rl, rd);
      prev_l_stall = lv && !lr;
      prev_r_stall = rv && !rr;
      prev_l = {ll, ld};
      prev_r = {rl, rd};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) begin
        lr = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Leaves in_valid high so consecutive calls are back-to-back; call idle() afterwards.
  task automatic send(input logic [15:0] d, input logic l, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waits++;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual not accepted, required accept of %0h", d);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_local_valid", {31'd0, lv}, 32'd0);
    check("reset_ring_valid", {31'd0, rv}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int w, acc, hdr_slot;
    logic pat [7];
    logic [15:0] d;
    logic l;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    do_reset();
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_local_idle", {31'd0, lv}, 32'd0);
    check("reset_ring_idle", {31'd0, rv}, 32'd0);
    @(posedge clk);
    #1;

    // Local 3-flit worm.
    send(16'h0005, 1'b0, w); send(16'hAAAA, 1'b0, w); send(16'hBBBB, 1'b1, w); idle();
    drain();

    // Single ring flit followed by a local worm with no idle bubble.
    send(16'h0007, 1'b1, w);
    send(16'h0005, 1'b0, w);
    check("no_stall_after_single", w, 32'd1);
    send(16'h1234, 1'b1, w); idle();
    drain();

    // Ring worm under toggling ring ready.
    fork
      begin
        send(16'h0009, 1'b0, w); send(16'h0001, 1'b0, w);
        send(16'h0002, 1'b0, w); send(16'h0003, 1'b1, w); idle();
      end
      begin
        for (int i = 0; i < 7; i++) begin
          rr = pat[i];
          @(posedge clk);
          #1;
        end
        rr = 1'b1;
      end
    join
    drain();

    // Payload equal to ID stays in the ring worm.
    send(16'h0009, 1'b0, w); send(16'h0005, 1'b0, w); send(16'h0005, 1'b1, w); idle();
    drain();

    // Reset mid-worm, then a fresh header.
    send(16'h0005, 1'b0, w); send(16'h0001, 1'b0, w); idle();
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    send(16'h0003, 1'b1, w); idle();
    drain();

    // Latency of a single flit.
    in_valid = 1'b1; in_data = 16'h0005; in_last = 1'b1;
    @(negedge clk);
`ifdef RING_ROUTER_INPUT_DEMUX_SKID_EN
    check("latency_cycle0", {31'd0, lv}, 32'd0);
`else
    check("latency_cycle0", {31'd0, lv}, 32'd1);
`endif
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
`ifdef RING_ROUTER_INPUT_DEMUX_SKID_EN
    check("latency_cycle1", {31'd0, lv}, 32'd1);
`else
    check("latency_cycle1", {31'd0, lv}, 32'd0);
`endif
    @(posedge clk);
    #1;
    drain();

    // Eight back-to-back flits at full rate.
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 16'h0005 : 16'(16'h100 + i), (i == 7), w);
      check("full_rate_accept", w, 32'd1);
    end
    idle();
    drain();

    // Backpressure: only the skid can absorb flits while outputs stall.
    lr = 1'b0; rr = 1'b0;
    acc = 0;
    fork
      begin
        send(16'h0009, 1'b0, w); send(16'h0011, 1'b0, w);
        send(16'h0022, 1'b0, w); send(16'h0033, 1'b1, w); idle();
      end
      begin
        repeat (3) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
        end
        @(posedge clk);
        #1;
        lr = 1'b1; rr = 1'b1;
      end
    join
`ifdef RING_ROUTER_INPUT_DEMUX_SKID_EN
    check("stall_accepted", acc, 32'd2);
`else
    check("stall_accepted", acc, 32'd0);
`endif
    drain();

    // Random traffic with random readies and gaps.
    rand_ready = 1'b1;
    hdr_slot = 1;
    for (int i = 0; i < 300; i++) begin
      if (hdr_slot != 0) d = ($urandom_range(0, 1) != 0) ? ID : 16'($urandom_range(0, 15));
      else d = ($urandom_range(0, 4) == 0) ? ID : 16'($urandom);
      l = (i == 299) || ($urandom_range(0, 3) == 0);
      send(d, l, w);
      hdr_slot = l ? 1 : 0;
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    idle();
    rand_ready = 1'b0;
    #1;
    lr = 1'b1; rr = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
